uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, meaning the iCE_CLK frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the line bit rate; DIV = CLK_HZ/BAUD is the number of clocks per bit, integer-truncated, minimum 2.
REQ-003 SHALL have port iCE_CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port TX_BYTE  input  8  byte to send, sampled only at accept.
REQ-006 SHALL have port VALID  input  1  TX_BYTE is offered.
REQ-007 SHALL have port READY  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port BUSY  output  1  a frame is in progress.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse when a frame completes.
REQ-010 SHALL have port TX  output  1  serial line, idle high.

Function
REQ-011 SHALL treat accept as VALID and READY both high on the same rising edge.
REQ-012 SHALL drive READY high only in state IDLE, and low in every other state.
REQ-013 SHALL have states IDLE, START, DATA, PARITY and STOP.
- IDLE goes to START on accept.
- START goes to DATA after DIV clocks.
- DATA goes to PARITY (macro defined) or STOP (macro undefined) after 8 x DIV clocks.
- PARITY goes to STOP after DIV clocks.
- STOP goes to IDLE after DIV clocks.
REQ-014 SHALL latch TX_BYTE into a shift register at accept; later changes to TX_BYTE or VALID SHALL NOT affect the frame.
REQ-015 SHALL drive TX low starting on the first cycle after accept, giving a latency of 1 clock.
REQ-016 SHALL hold each bit on TX for exactly DIV clocks.
REQ-017 SHALL send data bits LSB first.
REQ-018 SHALL send a stop bit that is high for exactly one bit time.
REQ-019 SHALL restart the bit counter at zero on each accept, so bit edges are phase-locked to the accept edge.
REQ-020 SHALL assert BUSY in every state except IDLE.
REQ-021 SHALL pulse DONE high for exactly one clock, on the last cycle of STOP; READY SHALL be high on the next cycle.
REQ-022 SHALL allow back-to-back frames: a VALID held high is accepted on the first IDLE cycle, so there is exactly one idle-high cycle between consecutive frames.
REQ-023 SHALL ignore VALID while BUSY, with no queuing and no error.
REQ-024 SHALL keep TX high whenever in IDLE.

Reset
REQ-025 SHALL, while RST_N is low, immediately force the following, independent of the clock: TX=1, READY=0, BUSY=0, DONE=0, state=IDLE, counters=0.
REQ-026 SHALL abandon any frame in progress when reset is asserted mid-frame, with no DONE pulse.
REQ-027 SHALL drive READY high on the first clock edge after RST_N deasserts.

Configuration
REQ-028 SHALL insert an even-parity bit after bit 7 when UART_TX_PARITY_EN is defined; the bit is the XOR of the 8 data bits, so the total number of ones is even. The frame is then 11 bit-times.
REQ-029 SHALL, without UART_TX_PARITY_EN, omit the PARITY state entirely, giving a 10 bit-time frame.

Structure
REQ-030 SHALL take the state enum typedef and the default CLK_HZ and BAUD constants from shared package uart_pkg.
REQ-031 SHALL implement bit timing in one sub-module, uart_baud_gen, which has a synchronous clear and produces a one-cycle tick every DIV clocks.

Verification (CLK_HZ=4, BAUD=1, so DIV=4, unless stated otherwise)
REQ-032 SHALL check: accept 0x55 with no parity -> TX is 0 then 1,0,1,0,1,0,1,0 then 1, each level held 4 clocks, and DONE pulses at clock 40 after accept.
REQ-033 SHALL check: VALID held high with 0xA3 then 0x0F -> two full frames, exactly 1 idle-high cycle between them, and two DONE pulses.
REQ-034 SHALL check: with UART_TX_PARITY_EN and 0x07 -> the parity bit is 1 and the frame is 44 clocks; with 0x03 -> the parity bit is 0.
REQ-035 SHALL check: RST_N pulled low during bit 3 -> TX=1 asynchronously, no DONE, and READY=1 on the first edge after release.
REQ-036 SHALL check: VALID pulsed with 0xFF during DATA of a 0x00 frame -> the 0x00 frame is unaffected and the 0xFF byte is never sent.
REQ-037 SHALL check: TX_BYTE changed on the cycle after accept -> the originally latched byte is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int CLK_HZ_DEF = 12000000;
    localparam int BAUD_DEF   = 9600;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_state_e;

    // Clocks per bit, integer-truncated and never below 2.
    function automatic int clk_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / baud;
        return (d < 2) ? 2 : d;
    endfunction

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time generator: one-cycle tick every DIV clocks, restartable by a synchronous clear.
module uart_baud_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick,
    output logic tick_next
);

    localparam int            CW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next count: cleared on request, wrapping at the last clock of the bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        tick_d = (cnt_d == LAST);
    end

    // Counter and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick      = tick_q;
    assign tick_next = tick_d;

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter, LSB first, one stop bit, registered outputs.
// Define UART_TX_PARITY_EN to append an even-parity bit after bit 7.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEF,
    parameter int BAUD   = BAUD_DEF
) (
    input  logic       iCE_CLK,
    input  logic       RST_N,
    input  logic [7:0] TX_BYTE,
    input  logic       VALID,
    output logic       READY,
    output logic       BUSY,
    output logic       DONE,
    output logic       TX
);

    localparam int DIV = clk_div(CLK_HZ, BAUD);

    uart_state_e state_q, state_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept_s;
    logic        tick_s;
    logic        tick_next_s;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    assign accept_s = VALID && ready_q;

    // The bit timer restarts on accept so bit edges are locked to the accept edge.
    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk       (iCE_CLK),
        .rst_n     (RST_N),
        .clr       (accept_s),
        .tick      (tick_s),
        .tick_next (tick_next_s)
    );

    // Next state, shift register and bit index.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = START;
                    shift_d = TX_BYTE;
                    bit_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                    par_d   = even_parity(TX_BYTE);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tick_s && (bit_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else if (tick_s) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                end else begin
                    state_d = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick_s) begin
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
`endif
            STOP: begin
                if (tick_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are derived from the next state so they register alongside it.
    always_comb begin
        tx_d    = 1'b1;
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == STOP) && tick_next_s;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge iCE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign TX    = tx_q;
    assign READY = ready_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule
